// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: valid/ready request handshake to external memory,
// splitting of word-crossing accesses into two aligned beats, and load extension.
module mem_access_unit #(
  parameter int unsigned XLEN           = 32,
  parameter bit          MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Req_Valid_M,
  input  logic              Req_Write_M,
  input  logic [1:0]        Req_Size_M,
  input  logic              Req_Unsigned_M,
  input  logic [XLEN-1:0]   Req_Adr_M,
  input  logic [XLEN-1:0]   Req_WriteData_M,
  output logic              Stall_M,
  output logic              Resp_Valid_M,
  output logic [XLEN-1:0]   LoadData_M,
  output logic              Fault_M,
  output logic              Ext_ReqValid,
  input  logic              Ext_ReqReady,
  output logic              Ext_Write,
  output logic [XLEN-1:0]   Ext_Adr,
  output logic [XLEN/8-1:0] Ext_ByteEn,
  output logic [XLEN-1:0]   Ext_WriteData,
  input  logic              Ext_RespValid,
  input  logic [XLEN-1:0]   Ext_ReadData
);

  localparam int unsigned BYTES  = XLEN / 8;
  localparam int unsigned OFS    = $clog2(BYTES);
  localparam int unsigned LANES2 = 2 * BYTES;

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t              state;

  logic [OFS-1:0]      cap_off;
  logic [1:0]          cap_sz;
  logic                cap_uns;
  logic                cap_write;
  logic                cap_split;
  logic [XLEN-1:0]     cap_adr1;
  logic [BYTES-1:0]    cap_be1;
  logic [XLEN-1:0]     cap_wd1;
  logic [XLEN-1:0]     beat0;

  logic [OFS-1:0]      in_off;
  logic [1:0]          in_sz;
  logic [LANES2-1:0]   in_mask;
  logic                in_split;
  logic [2*XLEN-1:0]   in_wd2;
  logic [XLEN-1:0]     in_adr0;

  logic [2*XLEN-1:0]   rd2;
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     ld_ext;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0] sz,
                                             input logic uns);
    logic [XLEN-1:0] r;
    r = v;
    case (sz)
      2'd0:    r = uns ? XLEN'(v[7:0])  : XLEN'(signed'(v[7:0]));
      2'd1:    r = uns ? XLEN'(v[15:0]) : XLEN'(signed'(v[15:0]));
      2'd2:    r = uns ? XLEN'(v[31:0]) : XLEN'(signed'(v[31:0]));
      default: r = v;
    endcase
    return r;
  endfunction

  // Lane arithmetic for a new request, evaluated straight off the M-stage inputs
  // so the first beat can be presented on the cycle after acceptance.
  always_comb begin
    in_off   = Req_Adr_M[OFS-1:0];
    in_sz    = (32'(Req_Size_M) > OFS) ? 2'(OFS) : Req_Size_M;
    in_mask  = LANES2'((32'd1 << (32'd1 << in_sz)) - 32'd1) << in_off;
    in_split = |in_mask[LANES2-1:BYTES];
    in_wd2   = {{XLEN{1'b0}}, Req_WriteData_M} << {in_off, 3'b000};
    in_adr0  = {Req_Adr_M[XLEN-1:OFS], {OFS{1'b0}}};
  end

  always_comb begin
    rd2    = cap_split ? {Ext_ReadData, beat0} : {{XLEN{1'b0}}, Ext_ReadData};
    raw    = XLEN'(rd2 >> {cap_off, 3'b000});
    ld_ext = extend(raw, cap_sz, cap_uns);
  end

  always_comb begin
    Stall_M = 1'b0;
    if (state == IDLE) Stall_M = Req_Valid_M & reset_n;
    else               Stall_M = (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      Resp_Valid_M  <= 1'b0;
      LoadData_M    <= '0;
      Fault_M       <= 1'b0;
      Ext_ReqValid  <= 1'b0;
      Ext_Write     <= 1'b0;
      Ext_Adr       <= '0;
      Ext_ByteEn    <= '0;
      Ext_WriteData <= '0;
      cap_off       <= '0;
      cap_sz        <= '0;
      cap_uns       <= 1'b0;
      cap_write     <= 1'b0;
      cap_split     <= 1'b0;
      cap_adr1      <= '0;
      cap_be1       <= '0;
      cap_wd1       <= '0;
      beat0         <= '0;
    end else begin
      Resp_Valid_M <= 1'b0;
      Fault_M      <= 1'b0;
      LoadData_M   <= '0;
      case (state)
        IDLE: begin
          if (Req_Valid_M) begin
            cap_off   <= in_off;
            cap_sz    <= in_sz;
            cap_uns   <= Req_Unsigned_M;
            cap_write <= Req_Write_M;
            cap_split <= in_split;
            cap_adr1  <= in_adr0 + XLEN'(BYTES);
            cap_be1   <= Req_Write_M ? in_mask[LANES2-1:BYTES] : '0;
            cap_wd1   <= Req_Write_M ? in_wd2[2*XLEN-1:XLEN] : '0;
            if (!MISALIGN_SPLIT && in_split) begin
              state        <= DONE;
              Resp_Valid_M <= 1'b1;
              Fault_M      <= 1'b1;
            end else begin
              state         <= REQ0;
              Ext_ReqValid  <= 1'b1;
              Ext_Write     <= Req_Write_M;
              Ext_Adr       <= in_adr0;
              Ext_ByteEn    <= Req_Write_M ? in_mask[BYTES-1:0] : '0;
              Ext_WriteData <= Req_Write_M ? in_wd2[XLEN-1:0] : '0;
            end
          end
        end
        REQ0, REQ1: begin
          if (Ext_ReqReady) begin
            state         <= (state == REQ0) ? RSP0 : RSP1;
            Ext_ReqValid  <= 1'b0;
            Ext_Write     <= 1'b0;
            Ext_Adr       <= '0;
            Ext_ByteEn    <= '0;
            Ext_WriteData <= '0;
          end
        end
        RSP0: begin
          if (Ext_RespValid) begin
            beat0 <= Ext_ReadData;
            if (cap_split) begin
              state         <= REQ1;
              Ext_ReqValid  <= 1'b1;
              Ext_Write     <= cap_write;
              Ext_Adr       <= cap_adr1;
              Ext_ByteEn    <= cap_be1;
              Ext_WriteData <= cap_wd1;
            end else begin
              state        <= DONE;
              Resp_Valid_M <= 1'b1;
              LoadData_M   <= cap_write ? '0 : ld_ext;
            end
          end
        end
        RSP1: begin
          if (Ext_RespValid) begin
            state        <= DONE;
            Resp_Valid_M <= 1'b1;
            LoadData_M   <= cap_write ? '0 : ld_ext;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: split and unsplit loads/stores, ready
// back-pressure, address wrap, misalign fault variant and mid-access reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, n_req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_adr, req_wdata;
  logic        ext_ready, ext_resp;
  logic [31:0] ext_rdata;

  logic        stall, resp_valid, fault, ext_valid, ext_write;
  logic [31:0] load_data, ext_adr, ext_wdata;
  logic [3:0]  ext_be;

  logic        n_stall, n_resp_valid, n_fault, n_ext_valid, n_ext_write;
  logic [31:0] n_load_data, n_ext_adr, n_ext_wdata;
  logic [3:0]  n_ext_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .Req_Valid_M(req_valid), .Req_Write_M(req_write), .Req_Size_M(req_size),
    .Req_Unsigned_M(req_uns), .Req_Adr_M(req_adr), .Req_WriteData_M(req_wdata),
    .Stall_M(stall), .Resp_Valid_M(resp_valid), .LoadData_M(load_data), .Fault_M(fault),
    .Ext_ReqValid(ext_valid), .Ext_ReqReady(ext_ready), .Ext_Write(ext_write),
    .Ext_Adr(ext_adr), .Ext_ByteEn(ext_be), .Ext_WriteData(ext_wdata),
    .Ext_RespValid(ext_resp), .Ext_ReadData(ext_rdata)
  );

  mem_access_unit #(.XLEN(32), .MISALIGN_SPLIT(1'b0)) u_nosplit (
    .clk(clk), .reset_n(reset_n),
    .Req_Valid_M(n_req_valid), .Req_Write_M(req_write), .Req_Size_M(req_size),
    .Req_Unsigned_M(req_uns), .Req_Adr_M(req_adr), .Req_WriteData_M(req_wdata),
    .Stall_M(n_stall), .Resp_Valid_M(n_resp_valid), .LoadData_M(n_load_data), .Fault_M(n_fault),
    .Ext_ReqValid(n_ext_valid), .Ext_ReqReady(ext_ready), .Ext_Write(n_ext_write),
    .Ext_Adr(n_ext_adr), .Ext_ByteEn(n_ext_be), .Ext_WriteData(n_ext_wdata),
    .Ext_RespValid(ext_resp), .Ext_ReadData(ext_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".stall"}, stall, 1'b0);
    check({tag, ".resp"},  resp_valid, 1'b0);
    check({tag, ".load"},  load_data, 32'h0);
    check({tag, ".fault"}, fault, 1'b0);
    check({tag, ".evld"},  ext_valid, 1'b0);
    check({tag, ".ewr"},   ext_write, 1'b0);
    check({tag, ".eadr"},  ext_adr, 32'h0);
    check({tag, ".ebe"},   ext_be, 4'h0);
    check({tag, ".ewd"},   ext_wdata, 32'h0);
  endtask

  // One complete access on u_dut; beat timings are fixed so no wait is unbounded.
  task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] adr, input logic [31:0] wd, input int nb, input int dly,
                     input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                     input logic [31:0] rd0,
                     input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                     input logic [31:0] rd1, input logic [31:0] ld);
    logic [31:0] ea[2], ew[2], er[2];
    logic [3:0]  eb[2];
    ea[0] = a0; eb[0] = be0; ew[0] = wd0; er[0] = rd0;
    ea[1] = a1; eb[1] = be1; ew[1] = wd1; er[1] = rd1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_uns = uns;
    req_adr = adr; req_wdata = wd;
    #1;
    check({tag, ".stall_req"}, stall, 1'b1);
    cyc();
    for (int b = 0; b < nb; b++) begin
      check($sformatf("%s.evld%0d", tag, b), ext_valid, 1'b1);
      check($sformatf("%s.ewr%0d",  tag, b), ext_write, wr);
      check($sformatf("%s.eadr%0d", tag, b), ext_adr, ea[b]);
      check($sformatf("%s.ebe%0d",  tag, b), ext_be, eb[b]);
      check($sformatf("%s.ewd%0d",  tag, b), ext_wdata, ew[b]);
      for (int k = 0; k < ((b == 0) ? dly : 0); k++) begin
        cyc();
        check($sformatf("%s.hold_vld%0d", tag, k), ext_valid, 1'b1);
        check($sformatf("%s.hold_adr%0d", tag, k), ext_adr, ea[b]);
        check($sformatf("%s.hold_be%0d",  tag, k), ext_be, eb[b]);
        check($sformatf("%s.hold_stl%0d", tag, k), stall, 1'b1);
      end
      ext_ready = 1'b1;
      cyc();
      ext_ready = 1'b0;
      check($sformatf("%s.rsp_vld%0d", tag, b), ext_valid, 1'b0);
      check($sformatf("%s.rsp_stl%0d", tag, b), stall, 1'b1);
      ext_resp = 1'b1; ext_rdata = er[b];
      cyc();
      ext_resp = 1'b0; ext_rdata = '0;
      if (b < nb - 1) check($sformatf("%s.no_early_resp%0d", tag, b), resp_valid, 1'b0);
    end
    check({tag, ".resp"},  resp_valid, 1'b1);
    check({tag, ".stall"}, stall, 1'b0);
    check({tag, ".load"},  load_data, ld);
    check({tag, ".fault"}, fault, 1'b0);
    req_valid = 1'b0;
    cyc();
    check({tag, ".resp_end"}, resp_valid, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; n_req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_adr = '0; req_wdata = '0;
    ext_ready = 1'b0; ext_resp = 1'b0; ext_rdata = '0;
    cyc(); cyc();
    check_idle("rst");
    reset_n = 1'b1;
    cyc();

    // Fault variant: word load crossing a word boundary, no external traffic.
    n_req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_adr = 32'h5002;
    #1;
    check("flt.stall_req", n_stall, 1'b1);
    cyc();
    check("flt.resp",  n_resp_valid, 1'b1);
    check("flt.fault", n_fault, 1'b1);
    check("flt.load",  n_load_data, 32'h0);
    check("flt.evld",  n_ext_valid, 1'b0);
    check("flt.stall", n_stall, 1'b0);
    n_req_valid = 1'b0;
    cyc();
    check("flt.resp_end",  n_resp_valid, 1'b0);
    check("flt.fault_end", n_fault, 1'b0);
    check("flt.evld_end",  n_ext_valid, 1'b0);

    //   tag         wr  sz  uns adr           wdata         nb dly a0            be0   wd0           rd0           a1            be1   wd1           rd1           load
    run("st_w1003",  1, 2'd2, 0, 32'h00001003, 32'hAABBCCDD, 2, 0, 32'h00001000, 4'h8, 32'hDD000000, 32'h0,        32'h00001004, 4'h7, 32'h00AABBCC, 32'h0,        32'h0);
    run("ld_sh2002", 0, 2'd1, 0, 32'h00002002, 32'h0,        1, 0, 32'h00002000, 4'h0, 32'h0,        32'h80FF1234, 32'h0,        4'h0, 32'h0,        32'h0,        32'hFFFF80FF);
    run("ld_ub3001", 0, 2'd0, 1, 32'h00003001, 32'h0,        1, 0, 32'h00003000, 4'h0, 32'h0,        32'h0000AB00, 32'h0,        4'h0, 32'h0,        32'h0,        32'h000000AB);
    run("ld_sh4003", 0, 2'd1, 0, 32'h00004003, 32'h0,        2, 0, 32'h00004000, 4'h0, 32'h0,        32'h11000000, 32'h00004004, 4'h0, 32'h0,        32'h00000022, 32'h00002211);
    run("st_b6002",  1, 2'd0, 1, 32'h00006002, 32'h0000005A, 1, 3, 32'h00006000, 4'h4, 32'h005A0000, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        32'h0);
    run("st_h7001",  1, 2'd1, 0, 32'h00007001, 32'h0000BEEF, 1, 0, 32'h00007000, 4'h6, 32'h00BEEF00, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        32'h0);
    run("ld_sb8003", 0, 2'd0, 0, 32'h00008003, 32'h0,        1, 0, 32'h00008000, 4'h0, 32'h0,        32'h80000000, 32'h0,        4'h0, 32'h0,        32'h0,        32'hFFFFFF80);
    run("ld_uh9002", 0, 2'd1, 1, 32'h00009002, 32'h0,        1, 0, 32'h00009000, 4'h0, 32'h0,        32'h80FF0000, 32'h0,        4'h0, 32'h0,        32'h0,        32'h000080FF);
    run("ld_clampB", 0, 2'd3, 0, 32'h0000B000, 32'h0,        1, 1, 32'h0000B000, 4'h0, 32'h0,        32'h87654321, 32'h0,        4'h0, 32'h0,        32'h0,        32'h87654321);
    run("st_wwrap",  1, 2'd2, 0, 32'hFFFFFFFE, 32'h11223344, 2, 0, 32'hFFFFFFFC, 4'hC, 32'h33440000, 32'h0,        32'h00000000, 4'h3, 32'h00001122, 32'h0,        32'h0);

    // Reset while waiting for the response, then a stray response in IDLE.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_adr = 32'h0000C000;
    cyc();
    ext_ready = 1'b1;
    cyc();
    ext_ready = 1'b0;
    reset_n = 1'b0; req_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    check_idle("midrst");
    ext_resp = 1'b1; ext_rdata = 32'hFFFFFFFF;
    cyc();
    ext_resp = 1'b0; ext_rdata = '0;
    check_idle("late_rsp");
    cyc();
    check("late_rsp.resp2", resp_valid, 1'b0);
    run("post_rst",  0, 2'd2, 0, 32'h0000D000, 32'h0,        1, 0, 32'h0000D000, 4'h0, 32'h0,        32'hCAFEF00D, 32'h0,        4'h0, 32'h0,        32'h0,        32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine for the pipelined core, in place of the pure pass-through memory stage.
- Adds a valid/ready request and response handshake to external memory, with variable latency.
- Splits misaligned accesses that cross a word boundary into two aligned beats.
- Performs load byte-lane extraction and sign or zero extension internally.
- Stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, datapath and address width (32 or 64).
- MISALIGN_SPLIT, 1: 1 = split boundary-crossing accesses into two beats; 0 = flag them as a fault with no external traffic.
- Derived: BYTES = XLEN/8; OFS = log2(BYTES).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- Req_Valid_M  in  1  a load or store is present in the M stage.
- Req_Write_M  in  1  1 = store.
- Req_Size_M  in  2  0 = byte, 1 = half, 2 = word, 3 = dword; sizes above OFS clamp to OFS.
- Req_Unsigned_M  in  1  zero-extend the load.
- Req_Adr_M  in  XLEN  byte address.
- Req_WriteData_M  in  XLEN  store data, right-justified.
- Stall_M  out  1  freeze the pipeline.
- Resp_Valid_M  out  1  one-cycle pulse: access complete.
- LoadData_M  out  XLEN  extended load result, valid with Resp_Valid_M.
- Fault_M  out  1  misalign fault, pulses with Resp_Valid_M.
- Ext_ReqValid  out  1  request valid.
- Ext_ReqReady  in  1  memory accepts the request.
- Ext_Write  out  1  request is a write.
- Ext_Adr  out  XLEN  word-aligned address; low OFS bits are always 0.
- Ext_ByteEn  out  BYTES  write byte lanes.
- Ext_WriteData  out  XLEN  lane-positioned write data.
- Ext_RespValid  in  1  read data valid, or write acknowledge.
- Ext_ReadData  in  XLEN  read word.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE.
  - All outputs are 0; captured request and beat-0 data registers are cleared.
  - Reset mid-access abandons the access. A late Ext_RespValid arriving in IDLE is ignored.
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE:
  - On Req_Valid_M: capture the request, Stall_M = 1 (combinational), go to REQ0.
  - If MISALIGN_SPLIT = 0 and the access is split: go to DONE with the fault flag set.
- REQ0 / REQ1:
  - Ext_ReqValid = 1; address, byte enables and data are held stable until Ext_ReqReady.
  - On the handshake, go to RSP0 / RSP1 respectively.
- RSP0:
  - On Ext_RespValid, capture Ext_ReadData as beat0.
  - Go to REQ1 if split, else DONE.
- RSP1:
  - On Ext_RespValid, go to DONE.
- DONE:
  - Stall_M = 0, Resp_Valid_M = 1 for exactly one cycle, then go to IDLE.
  - Fault_M = 1 only for fault completions, with LoadData_M = 0.
- Stall_M:
  - Equals 1 in every state except DONE, and is also 1 in IDLE while Req_Valid_M is high.
  - The pipeline holds the Req_* inputs stable while stalled; the unit uses only captured copies.
- Lane arithmetic (off = Adr[OFS-1:0]):
  - mask2 = ((1 << 2^size) - 1) << off, 2*BYTES wide.
  - beat0 ByteEn = mask2 low half; beat1 ByteEn = mask2 high half.
  - split = (high half != 0).
  - Write data = Req_WriteData_M << 8*off, 2*XLEN wide; beat0 takes the low half, beat1 the high half.
  - Beat0 address = Adr with the low OFS bits cleared; beat1 address = beat0 address + BYTES, wrapping modulo 2^XLEN.
- Loads:
  - Ext_ByteEn = 0 and Ext_WriteData = 0.
  - raw = {beat1, beat0} >> 8*off (or beat0 >> 8*off if not split).
  - Take the low 2^size bytes; sign- or zero-extend per Req_Unsigned_M.
- Stores complete on the ack (Ext_RespValid); LoadData_M = 0.
- Minimum latency, unsplit access with ready and response each one cycle after the request: IDLE → REQ0 → RSP0 → DONE, Resp_Valid_M 3 cycles after Req_Valid_M. A split access adds 2 cycles.

Test Plan:
- Store word 0xAABBCCDD to 0x1003, split=1:
  - beat0: Adr 0x1000, ByteEn 0b1000, data 0xDD000000.
  - beat1: Adr 0x1004, ByteEn 0b0111, data 0x00AABBCC.
  - One Resp_Valid_M pulse after the second ack.
- Signed half load at 0x2002, ReadData 0x80FF1234 → LoadData_M 0xFFFF80FF. Unsigned byte at 0x3001, ReadData 0x0000AB00 → 0x000000AB.
- Signed half load at 0x4003:
  - beat0 read 0x11000000 at 0x4000; beat1 read 0x00000022 at 0x4004.
  - Result: LoadData_M 0x00002211.
- Ext_ReqReady held low 3 cycles in REQ0:
  - Ext_ReqValid, Ext_Adr and Ext_ByteEn stay constant and Stall_M stays 1.
  - Completes normally once ready.
- MISALIGN_SPLIT=0, word load at 0x5002:
  - No Ext_ReqValid.
  - Resp_Valid_M and Fault_M both pulse 1 cycle after the request.
- reset_n low during RSP0, then Ext_RespValid high in IDLE:
  - Outputs are 0, with no Resp_Valid_M.
  - The next request completes correctly.
